imem_loader: RTL and testbench

Boot-time instruction loader that sits directly upstream of the instruction memory. It holds the core in reset and accepts a byte stream on a valid/ready interface. It assembles 9-bit instructions from byte pairs and writes them sequentially into instruction memory from address 0. It checks a trailing XOR checksum, then releases the core's reset.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state encoding for the boot-time instruction loader.
package imem_loader_pkg;

  localparam int INST_W = 9;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    S_CNT,
    S_LO,
    S_HI,
    S_SUM,
    S_DONE
  } state_e;

endpackage

// File: rtl/imem_loader.sv
// Loads a byte-pair encoded image into instruction memory from address 0 while
// holding the core in reset; releases it once the trailing XOR checksum is seen.
//
// Handshake: a byte transfers on a posedge where in_valid && in_ready. in_ready
// depends only on state (and rst), never on in_valid. A byte offered on the same
// edge as reload is dropped.
module imem_loader #(
  parameter int INST_W = imem_loader_pkg::INST_W,
  parameter int ADDR_W = imem_loader_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0] imem_data,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  import imem_loader_pkg::*;

  state_e              state_q, state_d;
  logic [8:0]          remaining_q, remaining_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          xor_q, xor_d;
  logic [7:0]          lo_q, lo_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [INST_W-1:0]   imem_data_q, imem_data_d;
  logic                core_rst_q, core_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept;

  assign in_ready = !rst && (state_q != S_DONE);
  assign accept   = in_valid && in_ready && !reload;

  // State register (plus datapath flops).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CNT;
      remaining_q <= '0;
      addr_q      <= '0;
      xor_q       <= '0;
      lo_q        <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      xor_q       <= xor_d;
      lo_q        <= lo_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (reload) begin
      state_d = S_CNT;
    end else if (accept) begin
      case (state_q)
        S_CNT:   state_d = S_LO;
        S_LO:    state_d = S_HI;
        S_HI:    state_d = (remaining_q > 9'd1) ? S_LO : S_SUM;
        S_SUM:   state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_comb begin
    remaining_d = remaining_q;
    addr_d      = addr_q;
    xor_d       = xor_q;
    lo_d        = lo_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    core_rst_d  = core_rst_q;
    done_d      = done_q;
    err_d       = err_q;
    if (reload) begin
      core_rst_d = 1'b1;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end else if (accept) begin
      case (state_q)
        S_CNT: begin
          // A count of zero encodes a full 256-word image.
          remaining_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          addr_d      = '0;
          xor_d       = '0;
        end
        S_LO: begin
          lo_d  = in_data;
          xor_d = xor_q ^ in_data;
        end
        S_HI: begin
          imem_we_d   = 1'b1;
          imem_addr_d = addr_q;
          imem_data_d = INST_W'({in_data[0], lo_q});
          xor_d       = xor_q ^ in_data;
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 9'd1;
          if (|in_data[7:1]) err_d = 1'b1;
        end
        S_SUM: begin
          done_d     = 1'b1;
          core_rst_d = 1'b0;
          if (in_data != xor_q) err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_we   = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_data = imem_data_q;
  assign core_rst  = core_rst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write scoreboard plus status checks per scenario.
module tb_imem_loader;

  localparam int INST_W = 9;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              reload;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              core_rst;
  logic              done;
  logic              err;

  int tests  = 0;
  int failed = 0;
  int we_cnt = 0;
  logic [ADDR_W+INST_W-1:0] exp_q[$];

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .reload   (reload),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .imem_we  (imem_we),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (imem_we) begin
      we_cnt++;
      if (exp_q.size() == 0) check("unexpected_write", 32'({imem_addr, imem_data}), 32'h1ffff);
      else check("write", 32'({imem_addr, imem_data}), 32'(exp_q.pop_front()));
    end
  end

  // Drivers
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [8:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    logic [7:0] lo, hi, sum;
    int base;
    rst = 1'b1; reload = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    // Reset state
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr_data", 32'({imem_addr, imem_data}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Two-instruction image, back-to-back
    push_exp(8'd0, 9'h134);
    push_exp(8'd1, 9'h0AB);
    send_byte(8'h02); send_byte(8'h34); send_byte(8'h01);
    check("lat_we", 32'(imem_we), 32'd1);
    check("lat_addr_data", 32'({imem_addr, imem_data}), 32'({8'd0, 9'h134}));
    send_byte(8'hAB); send_byte(8'h00);
    check("pre_sum_core_rst", 32'(core_rst), 32'd1);
    check("pre_sum_done", 32'(done), 32'd0);
    send_byte(8'h9E);
    check("t1_done", 32'(done), 32'd1);
    check("t1_core_rst", 32'(core_rst), 32'd0);
    check("t1_err", 32'(err), 32'd0);
    check("t1_ready_in_done", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t1_writes_left", 32'(exp_q.size()), 32'd0);

    // Bad checksum
    do_reload();
    check("reload_done", 32'(done), 32'd0);
    check("reload_core_rst", 32'(core_rst), 32'd1);
    push_exp(8'd0, 9'h134);
    push_exp(8'd1, 9'h0AB);
    send_byte(8'h02); send_byte(8'h34); send_byte(8'h01);
    send_byte(8'hAB); send_byte(8'h00); send_byte(8'h9F);
    check("badsum_done", 32'(done), 32'd1);
    check("badsum_err", 32'(err), 32'd1);
    check("badsum_core_rst", 32'(core_rst), 32'd0);
    @(negedge clk);
    check("badsum_writes_left", 32'(exp_q.size()), 32'd0);

    // Bad hi byte
    do_reload();
    check("reload_err_clear", 32'(err), 32'd0);
    push_exp(8'd0, 9'h110);
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h03);
    check("badhi_err_early", 32'(err), 32'd1);
    send_byte(8'h13);
    check("badhi_done", 32'(done), 32'd1);
    check("badhi_err", 32'(err), 32'd1);
    @(negedge clk);
    check("badhi_writes_left", 32'(exp_q.size()), 32'd0);

    // Full 256-word image with random gaps
    do_reload();
    base = we_cnt;
    sum  = 8'h00;
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      lo = 8'($urandom_range(0, 255));
      hi = 8'($urandom_range(0, 1));
      sum = sum ^ lo ^ hi;
      push_exp(8'(i), {hi[0], lo});
      idle($urandom_range(0, 3));
      send_byte(lo);
      idle($urandom_range(0, 3));
      send_byte(hi);
    end
    idle(2);
    check("full_done_before_sum", 32'(done), 32'd0);
    check("full_core_rst_before_sum", 32'(core_rst), 32'd1);
    check("full_write_count", 32'(we_cnt - base), 32'd256);
    send_byte(sum);
    check("full_done", 32'(done), 32'd1);
    check("full_err", 32'(err), 32'd0);
    check("full_core_rst", 32'(core_rst), 32'd0);
    check("full_writes_left", 32'(exp_q.size()), 32'd0);

    // Reload on the same edge as a hi byte
    do_reload();
    push_exp(8'd0, 9'h011);
    send_byte(8'h02); send_byte(8'h11); send_byte(8'hFE);
    check("mid_err_set", 32'(err), 32'd1);
    send_byte(8'h22);
    @(negedge clk);
    in_data = 8'h01; in_valid = 1'b1; reload = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; reload = 1'b0;
    check("mid_reload_err", 32'(err), 32'd0);
    check("mid_reload_core_rst", 32'(core_rst), 32'd1);
    check("mid_reload_done", 32'(done), 32'd0);
    check("mid_reload_no_we", 32'(imem_we), 32'd0);
    push_exp(8'd0, 9'h177);
    send_byte(8'h01); send_byte(8'h77); send_byte(8'h01); send_byte(8'h76);
    check("after_reload_done", 32'(done), 32'd1);
    check("after_reload_err", 32'(err), 32'd0);
    @(negedge clk);
    check("after_reload_writes_left", 32'(exp_q.size()), 32'd0);

    // Reset while in S_HI
    do_reload();
    push_exp(8'd0, 9'h112);
    push_exp(8'd1, 9'h034);
    send_byte(8'h03); send_byte(8'h12); send_byte(8'h01);
    send_byte(8'h34); send_byte(8'hFE); send_byte(8'h56);
    check("pre_rst_err", 32'(err), 32'd1);
    check("pre_rst_addr", 32'(imem_addr), 32'd1);
    rst = 1'b1; in_data = 8'h01; in_valid = 1'b1;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_mid_in_ready_after", 32'(in_ready), 32'd0);
    check("rst_mid_we", 32'(imem_we), 32'd0);
    check("rst_mid_addr_data", 32'({imem_addr, imem_data}), 32'd0);
    check("rst_mid_core_rst", 32'(core_rst), 32'd1);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ready_back", 32'(in_ready), 32'd1);
    push_exp(8'd0, 9'h005);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
    check("post_rst_load_done", 32'(done), 32'd1);
    check("post_rst_load_err", 32'(err), 32'd0);
    @(negedge clk);
    check("post_rst_writes_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
